// File: rtl/bram_flag_mailbox.sv
// PL->PS capture-ready mailbox: writes a flagged status word to a fixed BRAM
// address, waits for the PS to clear the flag (or time out), then rotates buffers.
module bram_flag_mailbox #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int FLAG_ADDR = 2047,
  parameter int WR_HOLD   = 3,
  parameter int RD_LAT    = 2,
  parameter int NBUF      = 2,
  parameter int TIMEOUT   = 0,
  localparam int BSW      = (NBUF > 1) ? $clog2(NBUF) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [DW-1:0]  dout,
  output logic           valid,
  output logic [DW-1:0]  din,
  output logic [AW-1:0]  addr,
  output logic           rst_count,
  output logic [BSW-1:0] buf_sel,
  output logic           busy,
  output logic           timeout
);

  localparam int SW     = DW - 16;
  localparam int HCW    = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
  // With RD_LAT=0 the earliest usable sample is still the first WAIT_ACK edge.
  localparam int QSTART = (RD_LAT < 1) ? 1 : RD_LAT;
  localparam int WLIM   = QSTART + ((TIMEOUT > 0) ? TIMEOUT : 1);
  localparam int WCW    = $clog2(WLIM + 1) + 1;
  localparam int TW     = WCW + 1;

  localparam logic [HCW-1:0] HOLD_LAST = HCW'(WR_HOLD - 1);
  localparam logic [TW-1:0]  QS_V      = TW'(QSTART);
  localparam logic [TW-1:0]  TO_LAST   = TW'(QSTART + TIMEOUT - 1);
  localparam logic [BSW-1:0] BUF_LAST  = BSW'(NBUF - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_valid, r_rst_count, r_busy, r_timeout;
  logic [DW-1:0]    r_din;
  logic [SW-1:0]    r_seq;
  logic [BSW-1:0]   r_buf_sel;
  logic [HCW-1:0]   r_hold;
  logic [WCW-1:0]   r_wcnt;

  logic             w_accept, w_wr_end, w_done;
  logic [TW-1:0]    w_ticks;
  logic             w_qual, w_ack, w_to;
  logic [DW-1:0]    w_word;
  logic             w_unused;

  assign addr      = AW'(FLAG_ADDR);
  assign valid     = r_valid;
  assign din       = r_din;
  assign rst_count = r_rst_count;
  assign buf_sel   = r_buf_sel;
  assign busy      = r_busy;
  assign timeout   = r_timeout;
  assign w_unused  = ^dout[DW-1:1];

  assign w_word  = {r_seq, 8'(r_buf_sel), 7'd0, 1'b1};

  // w_ticks counts WAIT_ACK edges including the current one.
  assign w_ticks = {1'b0, r_wcnt} + TW'(1);
  assign w_qual  = (w_ticks >= QS_V);
  assign w_ack   = w_qual && !dout[0];
  assign w_to    = (TIMEOUT != 0) && w_qual && !w_ack && (w_ticks >= TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_wr_end    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (en && !r_rst_count) begin
        w_accept    = 1'b1;
        w_state_nxt = S_WRITE;
      end
      S_WRITE: if (r_hold == HOLD_LAST) begin
        w_wr_end    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: if (w_ack || w_to) begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_din       <= '0;
      r_rst_count <= 1'b0;
      r_buf_sel   <= '0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_seq       <= '0;
      r_hold      <= '0;
      r_wcnt      <= '0;
    end else begin
      r_rst_count <= 1'b0;
      r_timeout   <= 1'b0;
      if (w_accept) begin
        r_din   <= w_word;
        r_valid <= 1'b1;
        r_busy  <= 1'b1;
        r_hold  <= '0;
      end
      if (r_state == S_WRITE) r_hold <= r_hold + HCW'(1);
      if (w_wr_end) begin
        r_valid <= 1'b0;
        r_wcnt  <= '0;
      end
      if (r_state == S_WAIT && r_wcnt != '1) r_wcnt <= r_wcnt + WCW'(1);
      if (w_done) begin
        r_rst_count <= 1'b1;
        r_timeout   <= w_to;
        r_din       <= '0;
        r_seq       <= r_seq + SW'(1);
        r_busy      <= 1'b0;
        r_buf_sel   <= (r_buf_sel == BUF_LAST) ? '0 : r_buf_sel + BSW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bram_flag_mailbox.sv
// Bench for bram_flag_mailbox: transaction-level model of word contents,
// ack/timeout edge timing, buffer rotation and seq wrap (DW=24, NBUF=3, TIMEOUT=16).
module tb_bram_flag_mailbox;
  localparam int DW = 24, AW = 16, FA = 2047, WH = 3, RL = 2, NB = 3, TO = 16;
  localparam int BSW = 2;

  logic           clk = 1'b0;
  logic           rst, en;
  logic [DW-1:0]  dout;
  logic           valid;
  logic [DW-1:0]  din;
  logic [AW-1:0]  addr;
  logic           rst_count;
  logic [BSW-1:0] buf_sel;
  logic           busy, timeout;

  int n_eval = 0, n_fail = 0;
  int exp_seq = 0, exp_buf = 0;

  always #5 clk = ~clk;

  bram_flag_mailbox #(
    .DW(DW), .AW(AW), .FLAG_ADDR(FA), .WR_HOLD(WH), .RD_LAT(RL),
    .NBUF(NB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .dout(dout), .valid(valid), .din(din),
    .addr(addr), .rst_count(rst_count), .buf_sel(buf_sel), .busy(busy),
    .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] word();
    return DW'(exp_seq * 65536 + exp_buf * 256 + 1);
  endfunction

  function automatic logic [DW-1:0] rnd_dout(input bit b0);
    logic [DW-1:0] d;
    d = DW'($urandom);
    d[0] = b0;
    return d;
  endfunction

  // k = index of the qualified sample that carries the ack; k >= TO means never.
  task automatic capture(input int k, input bit stale_zero, input bit hold_en);
    logic [DW-1:0] w;
    bit to_exp;
    int lastq;
    w = word();
    en = 1'b1;
    dout = rnd_dout(1'($urandom));
    tick();
    chk("accept_valid", valid, 1);
    chk("accept_din", din, w);
    chk("accept_busy", busy, 1);
    chk("accept_bufsel", buf_sel, exp_buf);
    for (int i = 1; i <= WH; i++) begin
      en = hold_en ? 1'b1 : 1'($urandom);
      dout = rnd_dout(stale_zero ? 1'b0 : 1'($urandom));
      tick();
      chk("hold_valid", valid, (i < WH) ? 1 : 0);
      chk("hold_din", din, w);
      chk("hold_busy", busy, 1);
    end
    to_exp = (k >= TO);
    lastq  = to_exp ? TO - 1 : k;
    for (int j = 1; j <= RL + lastq; j++) begin
      en = hold_en ? 1'b1 : 1'($urandom);
      if (j < RL) dout = rnd_dout(stale_zero ? 1'b0 : 1'($urandom));
      else        dout = rnd_dout((j - RL == k) ? 1'b0 : 1'b1);
      tick();
      if (j < RL + lastq) begin
        chk("wait_busy", busy, 1);
        chk("wait_rstcnt", rst_count, 0);
        chk("wait_valid", valid, 0);
      end
    end
    exp_seq = (exp_seq + 1) % 256;
    exp_buf = (exp_buf + 1) % NB;
    chk("done_rstcnt", rst_count, 1);
    chk("done_timeout", timeout, to_exp ? 1 : 0);
    chk("done_busy", busy, 0);
    chk("done_din", din, 0);
    chk("done_bufsel", buf_sel, exp_buf);
    en = hold_en ? 1'b1 : 1'($urandom);
    dout = rnd_dout(1'b1);
    tick();
    chk("post_rstcnt", rst_count, 0);
    chk("post_timeout", timeout, 0);
    chk("post_busy_en_ignored", busy, 0);
  endtask

  task automatic async_reset_during(input int edges_in);
    en = 1'b1;
    dout = rnd_dout(1'b1);
    tick();
    en = 1'b0;
    repeat (edges_in) tick();
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_din", din, 0);
    chk("arst_bufsel", buf_sel, 0);
    tick();
    tick();
    chk("arst_no_rstcnt", rst_count, 0);
    rst = 1'b0;
    exp_seq = 0;
    exp_buf = 0;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    en = 1'b0;
    dout = '1;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_din", din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rstcnt", rst_count, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_bufsel", buf_sel, 0);
    chk("addr", addr, FA);
    tick();
    tick();
    rst = 1'b0;

    chk("basic_word0", word(), 24'h000001);
    capture(3, 1'b0, 1'b0);
    chk("basic_word1", word(), 24'h010101);
    capture(3, 1'b0, 1'b0);
    capture(5, 1'b1, 1'b0);           // stale zeros ignored, completion at E0+10
    capture(TO + 3, 1'b0, 1'b0);      // timeout at E0+20
    capture(1, 1'b0, 1'b0);
    capture(TO - 1, 1'b0, 1'b0);      // ack coincides with timeout limit
    capture(0, 1'b0, 1'b0);
    repeat (5) capture($urandom_range(0, 4), 1'b0, 1'b0);

    async_reset_during(1);            // mid-WRITE
    capture(2, 1'b0, 1'b0);
    capture(1, 1'b0, 1'b0);
    async_reset_during(4);            // WAIT_ACK

    // Back-to-back with en held high; seq wraps past 255.
    for (int n = 0; n < 270; n++) begin
      k = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, 4);
      capture(k, 1'($urandom), 1'b1);
    end
    en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
